systolic_seq_ctrl: RTL and testbench



---
 rtl/systolic_seq_ctrl_pkg.sv | 21 ++
 rtl/systolic_seq_ctrl_seq_slot_timer.sv | 32 +++
 rtl/systolic_seq_ctrl.sv | 155 +++++++++++++++
 tb/tb_systolic_seq_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_seq_ctrl_pkg.sv
// systolic_pkg: shared defaults and FSM encoding for the systolic lane sequencer.
// Consumed by systolic_seq_ctrl; the SEQ_SLOT_PAD_EN build uses the S_PAD state.
package systolic_pkg;

    localparam int WORDLENGTH_DEF   = 16;
    localparam int NUM_WORDS_DEF    = 8;
    localparam int IDX_W_DEF        = 3;
    localparam int MULT_TIMEOUT_DEF = 40;
    localparam int TMR_W            = 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_WAIT_HI = 3'd2,
        S_WAIT_LO = 3'd3,
        S_ACC     = 3'd4,
        S_PAD     = 3'd5,
        S_ERR     = 3'd6
    } seq_state_e;

endpackage

// File: rtl/systolic_seq_ctrl_seq_slot_timer.sv
// seq_slot_timer: loadable up-counter with clear, enable and equality compare.
// Used for the multiplier timeout and, with SEQ_SLOT_PAD_EN, the slot padding.
module seq_slot_timer #(
    parameter int W = 8
) (
    input  logic         clk30x,
    input  logic         reset,
    input  logic         i_clear,
    input  logic         i_load,
    input  logic [W-1:0] i_loadVal,
    input  logic         i_en,
    input  logic [W-1:0] i_cmpVal,
    output logic [W-1:0] o_count,
    output logic         o_eq
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk30x) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_loadVal;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_eq    = (r_count == i_cmpVal);

endmodule

// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: busy-handshake sequencer for one systolic PE lane.
// Define SEQ_SLOT_PAD_EN to pad each word slot to at least timing+1 cycles.
module systolic_seq_ctrl
    import systolic_pkg::*;
#(
    parameter int WORDLENGTH   = WORDLENGTH_DEF,
    parameter int NUM_WORDS    = NUM_WORDS_DEF,
    parameter int IDX_W        = IDX_W_DEF,
    parameter int MULT_TIMEOUT = MULT_TIMEOUT_DEF
) (
    input  logic                  clk30x,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [WORDLENGTH-1:0] in_word,
    output logic                  in_ready,
    input  logic [IDX_W-1:0]      start_index,
    input  logic [31:0]           timing,
    output logic [WORDLENGTH-1:0] mult_a,
    output logic                  start_mult,
    input  logic                  mult_busy,
    output logic [IDX_W-1:0]      word_index,
    output logic [IDX_W-1:0]      coeff_sel,
    output logic                  first_word,
    output logic                  acc_en,
    output logic                  frame_done,
    output logic                  timeout_err
);

    seq_state_e             r_state;
    seq_state_e             w_nextState;
    logic [IDX_W-1:0]       r_wordCount;
    logic [IDX_W-1:0]       r_wordIndex;
    logic [WORDLENGTH-1:0]  r_multA;
    logic                   w_accept;
    logic                   w_waiting;
    logic                   w_tmoHit;
    logic [TMR_W-1:0]       w_unusedTmoCount;

    assign w_accept  = (r_state == S_IDLE) && in_valid;
    assign w_waiting = (r_state == S_WAIT_HI) || (r_state == S_WAIT_LO);

    // Timer restarts in START so it counts only the cycles spent waiting on busy.
    seq_slot_timer #(.W(TMR_W)) u_tmoTimer (
        .clk30x    (clk30x),
        .reset     (reset),
        .i_clear   (r_state == S_START),
        .i_load    (1'b0),
        .i_loadVal ('0),
        .i_en      (w_waiting),
        .i_cmpVal  (TMR_W'(MULT_TIMEOUT)),
        .o_count   (w_unusedTmoCount),
        .o_eq      (w_tmoHit)
    );

`ifdef SEQ_SLOT_PAD_EN
    logic [31:0] w_slotCount;
    logic        w_slotDone;
    logic        w_unusedSlotEq;

    // Loaded with 1 on acceptance so the count equals cycles elapsed since the accept.
    seq_slot_timer #(.W(32)) u_slotTimer (
        .clk30x    (clk30x),
        .reset     (reset),
        .i_clear   (1'b0),
        .i_load    (w_accept),
        .i_loadVal (32'd1),
        .i_en      (w_slotCount != '1),
        .i_cmpVal  (timing),
        .o_count   (w_slotCount),
        .o_eq      (w_unusedSlotEq)
    );

    assign w_slotDone = (w_slotCount >= timing);
`else
    logic w_unusedTiming;
    assign w_unusedTiming = ^timing;
`endif

    always_ff @(posedge clk30x) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:    if (in_valid) w_nextState = S_START;
            S_START:   w_nextState = S_WAIT_HI;
            S_WAIT_HI: begin
                if (w_tmoHit)       w_nextState = S_ERR;
                else if (mult_busy) w_nextState = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (w_tmoHit)        w_nextState = S_ERR;
                else if (!mult_busy) w_nextState = S_ACC;
            end
`ifdef SEQ_SLOT_PAD_EN
            S_ACC:     w_nextState = S_PAD;
            S_PAD:     if (w_slotDone) w_nextState = S_IDLE;
`else
            S_ACC:     w_nextState = S_IDLE;
            S_PAD:     w_nextState = S_IDLE;
`endif
            S_ERR:     w_nextState = S_ERR;
            default:   w_nextState = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready    = 1'b0;
        start_mult  = 1'b0;
        acc_en      = 1'b0;
        frame_done  = 1'b0;
        timeout_err = 1'b0;
        case (r_state)
            S_IDLE:  in_ready = !reset;
            S_START: start_mult = 1'b1;
            S_ACC: begin
                acc_en     = 1'b1;
                frame_done = (r_wordCount == IDX_W'(NUM_WORDS - 1));
            end
            S_ERR:   timeout_err = 1'b1;
            default: ;
        endcase
    end

    // word_index tracks start_q + word_count; start_index is only taken at frame start.
    always_ff @(posedge clk30x) begin
        if (reset) begin
            r_wordCount <= '0;
            r_wordIndex <= '0;
            r_multA     <= '0;
        end else begin
            if (w_accept) begin
                r_multA <= in_word;
                if (r_wordCount == '0) begin
                    r_wordIndex <= start_index;
                end
            end
            if (r_state == S_ACC) begin
                r_wordCount <= r_wordCount + 1'b1;
                r_wordIndex <= r_wordIndex + 1'b1;
            end
        end
    end

    assign mult_a     = r_multA;
    assign word_index = r_wordIndex;
    assign coeff_sel  = r_wordCount;
    assign first_word = (r_wordCount == '0);

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// tb_systolic_seq_ctrl: timestamp-based reference model plus directed vectors.
// Build with SEQ_SLOT_PAD_EN defined to exercise the slot-padding vectors too.
module tb_systolic_seq_ctrl;

    localparam int WL  = 16;
    localparam int NW  = 8;
    localparam int IW  = 3;
    localparam int TMO = 40;

    logic          clk30x = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [WL-1:0] in_word;
    logic          in_ready;
    logic [IW-1:0] start_index;
    logic [31:0]   timing;
    logic [WL-1:0] mult_a;
    logic          start_mult;
    logic          mult_busy;
    logic [IW-1:0] word_index;
    logic [IW-1:0] coeff_sel;
    logic          first_word;
    logic          acc_en;
    logic          frame_done;
    logic          timeout_err;

    always #5 clk30x = ~clk30x;

    systolic_seq_ctrl #(
        .WORDLENGTH(WL), .NUM_WORDS(NW), .IDX_W(IW), .MULT_TIMEOUT(TMO)
    ) dut (
        .clk30x(clk30x), .reset(reset), .in_valid(in_valid), .in_word(in_word),
        .in_ready(in_ready), .start_index(start_index), .timing(timing),
        .mult_a(mult_a), .start_mult(start_mult), .mult_busy(mult_busy),
        .word_index(word_index), .coeff_sel(coeff_sel), .first_word(first_word),
        .acc_en(acc_en), .frame_done(frame_done), .timeout_err(timeout_err)
    );

    int nVectors = 0;
    int nMiscompares = 0;
    int cyc = 0;

    // Model: each accepted word is a transaction with fixed timestamps derived from busy length.
    bit            chkEn = 0;
    bit            lastReady = 0;
    bit            acceptedNow = 0;
    bit            mActive = 0;
    bit            mHang = 0;
    bit            errSticky = 0;
    int            mAcc = 0;
    int            mAccCyc = 0;
    int            mErrCyc = 0;
    int            mIdleFrom = 0;
    int            nextLen = 16;
    int            mCount = 0;
    logic [IW-1:0] mStartQ = '0;
    logic [WL-1:0] mMultA = '0;
    int            busyFrom = 1;
    int            busyTo = 0;

    int            obsAccept[$];
    int            obsAccCyc[$];
    logic [IW-1:0] obsIdx[$];
    bit            obsFirst[$];
    bit            obsFrame[$];
    int            firstErrCyc = -1;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiscompares++;
            if (nMiscompares <= 40)
                $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic clearObs();
        obsAccept.delete();
        obsAccCyc.delete();
        obsIdx.delete();
        obsFirst.delete();
        obsFrame.delete();
        firstErrCyc = -1;
    endtask

    task automatic checkOutput();
        logic          eReady;
        logic          eStart;
        logic          eAcc;
        logic [IW-1:0] eIdx;
        if (!chkEn) begin
            lastReady = 1'b0;
            return;
        end
        eReady = !reset && !errSticky && !mActive;
        eStart = mActive && (cyc == mAcc + 1);
        eAcc   = mActive && !mHang && (cyc == mAccCyc);
        eIdx   = mStartQ + IW'(mCount);
        cmp("in_ready",    32'(in_ready),    32'(eReady));
        cmp("start_mult",  32'(start_mult),  32'(eStart));
        cmp("acc_en",      32'(acc_en),      32'(eAcc));
        cmp("frame_done",  32'(frame_done),  32'(eAcc && (mCount == NW - 1)));
        cmp("timeout_err", 32'(timeout_err), 32'(errSticky));
        cmp("word_index",  32'(word_index),  32'(eIdx));
        cmp("coeff_sel",   32'(coeff_sel),   32'(mCount));
        cmp("first_word",  32'(first_word),  32'(mCount == 0));
        cmp("mult_a",      32'(mult_a),      32'(mMultA));
        if (acc_en) begin
            obsAccCyc.push_back(cyc);
            obsIdx.push_back(word_index);
            obsFirst.push_back(first_word);
            obsFrame.push_back(frame_done);
        end
        if (in_valid && in_ready) obsAccept.push_back(cyc);
        if (timeout_err && firstErrCyc < 0) firstErrCyc = cyc;
        lastReady = eReady;
    endtask

    task automatic modelEdge();
        if (reset) begin
            chkEn     = 1;
            mActive   = 0;
            errSticky = 0;
            mCount    = 0;
            mStartQ   = '0;
            mMultA    = '0;
        end else begin
            if (mActive && !mHang && cyc == mAccCyc) mCount = (mCount + 1) % NW;
            if (mActive && mHang && cyc + 1 == mErrCyc) errSticky = 1;
            if (mActive && !mHang && cyc + 1 == mIdleFrom) mActive = 0;
            if (lastReady && in_valid) begin
                acceptedNow = 1;
                mActive = 1;
                mAcc    = cyc;
                mMultA  = in_word;
                if (mCount == 0) mStartQ = start_index;
                mHang   = (nextLen == 0) || (nextLen >= TMO);
                // busy high from start+1 for nextLen cycles; acc one cycle after first low sample
                mAccCyc = cyc + nextLen + 3;
                mErrCyc = cyc + TMO + 3;
`ifdef SEQ_SLOT_PAD_EN
                mIdleFrom = (mAccCyc + 2 > cyc + int'(timing) + 1) ? mAccCyc + 2 : cyc + int'(timing) + 1;
`else
                mIdleFrom = mAccCyc + 1;
`endif
                busyFrom = cyc + 2;
                busyTo   = cyc + 1 + nextLen;
            end
        end
    endtask

    task automatic stepCycle();
        @(negedge clk30x);
        checkOutput();
        @(posedge clk30x);
        #1;
        modelEdge();
        cyc++;
        mult_busy = (cyc >= busyFrom) && (cyc <= busyTo);
    endtask

    task automatic applyStimulus(input logic [WL-1:0] word, input logic [IW-1:0] sidx, input int len);
        int waitCycles;
        waitCycles  = 0;
        in_word     = word;
        start_index = sidx;
        nextLen     = len;
        in_valid    = 1;
        acceptedNow = 0;
        while (!acceptedNow && waitCycles < 300) begin
            stepCycle();
            waitCycles++;
        end
        in_valid = 0;
        cmp("accept_bound", 32'(acceptedNow), 32'd1);
    endtask

    task automatic doReset(input int n);
        in_valid = 0;
        reset    = 1;
        repeat (n) stepCycle();
        reset = 0;
    endtask

    int       lens3[9] = '{16, 1, 5, 39, 2, 7, 3, 10, 4};
    bit [2:0] expIdx3[9] = '{3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    bit       expFrame3[9] = '{0, 0, 0, 0, 0, 0, 0, 1, 0};
    bit       expFirst3[9] = '{1, 0, 0, 0, 0, 0, 0, 0, 1};
    int       nBefore;

    initial begin
        reset = 1; in_valid = 0; in_word = '0; start_index = '0; timing = '0; mult_busy = 0;

        // Reset then idle
        repeat (3) stepCycle();
        reset = 0;
        repeat (2) stepCycle();
        cmp("t1_in_ready", 32'(in_ready), 32'd1);
        cmp("t1_word_index", 32'(word_index), 32'd0);

        // Single word, busy 16 cycles: acc 19 cycles after acceptance
        clearObs();
        applyStimulus(16'h1234, 3'd0, 16);
        repeat (25) stepCycle();
        cmp("t2_acc_count", 32'(obsAccCyc.size()), 32'd1);
        if (obsAccCyc.size() > 0 && obsAccept.size() > 0) begin
            cmp("t2_acc_latency", 32'(obsAccCyc[0] - obsAccept[0]), 32'd19);
            cmp("t2_first_word", 32'(obsFirst[0]), 32'd1);
            cmp("t2_idx_at_acc", 32'(obsIdx[0]), 32'd0);
        end
        cmp("t2_mult_a", 32'(mult_a), 32'h1234);
        cmp("t2_word_index_after", 32'(word_index), 32'd1);

        // Back-to-back frame from 5, mid-frame start_index change ignored, next frame at 5
        doReset(2);
        clearObs();
        for (int i = 0; i < 9; i++)
            applyStimulus(16'h0100 + WL'(i), (i == 0 || i == 8) ? 3'd5 : 3'd2, lens3[i]);
        repeat (20) stepCycle();
        cmp("t3_acc_count", 32'(obsIdx.size()), 32'd9);
        for (int i = 0; i < obsIdx.size() && i < 9; i++) begin
            cmp("t3_word_index", 32'(obsIdx[i]), 32'(expIdx3[i]));
            cmp("t3_frame_done", 32'(obsFrame[i]), 32'(expFrame3[i]));
            cmp("t3_first_word", 32'(obsFirst[i]), 32'(expFirst3[i]));
        end

        // Busy never asserted: ERR appears 43 cycles after acceptance and sticks
        doReset(2);
        clearObs();
        applyStimulus(16'hBEEF, 3'd0, 0);
        in_valid = 1;
        repeat (145) stepCycle();
        in_valid = 0;
        cmp("t4_err_seen", 32'(firstErrCyc >= 0), 32'd1);
        if (firstErrCyc >= 0 && obsAccept.size() > 0)
            cmp("t4_err_latency", 32'(firstErrCyc - obsAccept[0]), 32'd43);
        cmp("t4_err_held", 32'(timeout_err), 32'd1);
        cmp("t4_ready_low", 32'(in_ready), 32'd0);
        doReset(1);
        stepCycle();
        cmp("t4_err_cleared", 32'(timeout_err), 32'd0);
        cmp("t4_ready_back", 32'(in_ready), 32'd1);

        // Busy 40 cycles: falls one cycle too late, timeout wins
        clearObs();
        applyStimulus(16'h0040, 3'd0, 40);
        repeat (50) stepCycle();
        if (firstErrCyc >= 0 && obsAccept.size() > 0)
            cmp("t4b_err_latency", 32'(firstErrCyc - obsAccept[0]), 32'd43);
        cmp("t4b_acc_count", 32'(obsAccCyc.size()), 32'd0);

        // Reset in WAIT_LO of word 3; late busy fall must not strobe
        doReset(2);
        clearObs();
        for (int i = 0; i < 3; i++) applyStimulus(16'h0200 + WL'(i), 3'd0, 4);
        applyStimulus(16'h3333, 3'd0, 16);
        repeat (7) stepCycle();
        reset = 1;
        stepCycle();
        reset = 0;
        cmp("t5_coeff_sel", 32'(coeff_sel), 32'd0);
        cmp("t5_mult_a", 32'(mult_a), 32'd0);
        nBefore = obsAccCyc.size();
        repeat (30) stepCycle();
        cmp("t5_no_acc", 32'(obsAccCyc.size()), 32'(nBefore));
        applyStimulus(16'h4444, 3'd6, 3);
        repeat (10) stepCycle();
        if (obsIdx.size() > 0) cmp("t5_restart_idx", 32'(obsIdx[$]), 32'd6);

`ifdef SEQ_SLOT_PAD_EN
        // Slot padding: timing=30 gives 31-cycle spacing; timing=3 adds one PAD cycle
        doReset(2);
        clearObs();
        timing = 32'd30;
        applyStimulus(16'h0A0A, 3'd0, 16);
        applyStimulus(16'h0B0B, 3'd0, 16);
        repeat (25) stepCycle();
        if (obsAccept.size() >= 2) cmp("t6_spacing_30", 32'(obsAccept[1] - obsAccept[0]), 32'd31);
        clearObs();
        timing = 32'd3;
        applyStimulus(16'h0C0C, 3'd0, 16);
        applyStimulus(16'h0D0D, 3'd0, 16);
        repeat (25) stepCycle();
        if (obsAccept.size() >= 2) cmp("t6_spacing_3", 32'(obsAccept[1] - obsAccept[0]), 32'd21);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
